// File: rtl/full_adder.sv
// full_adder: one-bit ripple-carry cell for the adder_64 datapath.
// Combinational sum/carry come from delayed gate primitives so a 64-deep
// chain shows realistic ripple timing in simulation. The block also has a
// registered copy of sum/carry and propagate/generate taps for lookahead logic.
// Optional build macro: FULLADDER_SELFCHECK_EN. When it is defined, a sticky
// err flag is raised when the gate network disagrees with a + b + ci.
`timescale 1ps/1fs

module full_adder #(
   parameter int GATE_DELAY = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic out,
   output logic co,
   output logic p,
   output logic g,
   output logic out_q,
   output logic co_q,
   output logic err
);

   wire x1_w;
   wire sum_w;
   wire gen_w;
   wire t_w;
   wire carry_w;

   // The carry path is three gates deep (x1 -> t -> co). This path sets the
   // per-bit ripple time of the chain. No X-masking is added, so unknowns
   // propagate with primitive semantics.
   xor #(GATE_DELAY) u_x1  (x1_w,    a,     b);
   xor #(GATE_DELAY) u_sum (sum_w,   x1_w,  ci);
   and #(GATE_DELAY) u_gen (gen_w,   a,     b);
   and #(GATE_DELAY) u_t   (t_w,     x1_w,  ci);
   or  #(GATE_DELAY) u_co  (carry_w, gen_w, t_w);

   assign p   = x1_w;
   assign g   = gen_w;
   assign out = sum_w;
   assign co  = carry_w;

   // Capture the settled sum/carry. Reset clears only this stage, never the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= 1'b0;
         co_q  <= 1'b0;
      end else begin
         out_q <= out;
         co_q  <= co;
      end
   end

`ifdef FULLADDER_SELFCHECK_EN
   logic [1:0] ref_sum;
   logic       err_r;

   // Reference sum from plain arithmetic, independent of the gate network
   always_comb ref_sum = {1'b0, a} + {1'b0, b} + {1'b0, ci};

   // Sticky mismatch flag; inputs carrying X/Z are not judged
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (!$isunknown({a, b, ci}) && ({co, out} != ref_sum)) begin
         err_r <= 1'b1;
         $error("full_adder mismatch t=%0t a=%b b=%b ci=%b {co,out}=%b%b", $time, a, b, ci, co, out);
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
`timescale 1ps/1fs

module tb_full_adder;
   localparam int GD = 50;

   logic clk = 1'b0;
   logic reset;
   logic a, b, ci;
   logic out, co, p, g, out_q, co_q, err;

   int  checks    = 0;
   int  failures  = 0;
   time last_chg  = 0;
   bit  q_known   = 1'b0;
   bit  pause_cmp = 1'b0;
   logic [1:0] exp_q = 2'b00;

   logic [1:0] exh_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
   logic       p_tab   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       g_tab   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   full_adder #(.GATE_DELAY(GD)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .ci(ci),
      .out(out), .co(co), .p(p), .g(g),
      .out_q(out_q), .co_q(co_q), .err(err)
   );

   // four-cell ripple chain
   logic [3:0] ca, cb;
   logic       cci;
   wire  [4:0] cc;
   wire  [3:0] csum, cp, cg, coq, ccq, cerr;
   assign cc[0] = cci;
   for (genvar k = 0; k < 4; k++) begin : g_chain
      full_adder #(.GATE_DELAY(GD)) u_cell (
         .clk(clk), .reset(reset), .a(ca[k]), .b(cb[k]), .ci(cc[k]),
         .out(csum[k]), .co(cc[k+1]), .p(cp[k]), .g(cg[k]),
         .out_q(coq[k]), .co_q(ccq[k]), .err(cerr[k])
      );
   end

   always #500 clk = ~clk;

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [2:0] v);
      {a, b, ci} = v;
      last_chg = $time;
   endtask

   // Model: the cell is a 1-bit adder, {co,out} is the count of ones in the inputs
   function automatic logic [1:0] model_sum(input logic [2:0] v);
      int n;
      n = int'(v[2]) + int'(v[1]) + int'(v[0]);
      return 2'(n);
   endfunction

   // propagate when exactly one of a,b is set, generate when both are
   function automatic logic [1:0] model_pg(input logic [2:0] v);
      int n;
      n = int'(v[2]) + int'(v[1]);
      return {n == 1, n == 2};
   endfunction

   function automatic bit settled();
      return ($time - last_chg) > 3 * GD;
   endfunction

   // What the register stage must show after this edge
   always @(posedge clk) begin
      if (reset === 1'b1) begin
         exp_q   = 2'b00;
         q_known = 1'b1;
      end else if (!pause_cmp && !$isunknown({a, b, ci}) && settled()) begin
         exp_q   = model_sum({a, b, ci});
         q_known = 1'b1;
      end else begin
         q_known = 1'b0;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (!pause_cmp) begin
         if (!$isunknown({a, b, ci}) && settled()) begin
            chk("cyc_sum", {3'b0, co, out}, {3'b0, model_sum({a, b, ci})});
            chk("cyc_pg",  {3'b0, p, g},    {3'b0, model_pg({a, b, ci})});
         end
         if (q_known) chk("cyc_q", {3'b0, co_q, out_q}, {3'b0, exp_q});
`ifndef FULLADDER_SELFCHECK_EN
         chk("cyc_err", {4'b0, err}, 5'b0);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ca = 4'b0; cb = 4'b0; cci = 1'b0;
      set_in(3'b000);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q",   {3'b0, co_q, out_q}, 5'b0);
      chk("reset_err", {4'b0, err}, 5'b0);
      @(negedge clk); #1;
      reset = 1'b0;

      // exhaustive truth table
      for (int i = 0; i < 8; i++) begin
         set_in(3'(i));
         #200;
         chk("exh_model", {3'b0, model_sum(3'(i))}, {3'b0, exh_tab[i]});
         chk("exh_sum",   {3'b0, co, out}, {3'b0, exh_tab[i]});
         chk("exh_pg",    {3'b0, p, g},    {3'b0, p_tab[i], g_tab[i]});
      end

      // gate timing
      @(negedge clk); #1;
      set_in(3'b000); #200;
      set_in(3'b111); #40;
      chk("tim_old",  {3'b0, co, out}, 5'b00000);
      #61;
      chk("tim_out",  {4'b0, out}, 5'b00001);
      #50;
      chk("tim_co",   {4'b0, co}, 5'b00001);
      set_in(3'b000); #200;
      set_in(3'b101); #140;
      chk("tim_co_slow_old", {4'b0, co}, 5'b00000);
      #11;
      chk("tim_co_slow_new", {3'b0, co, out}, 5'b00010);

      // unknown carry-in propagates
      set_in(3'b00x); #200;
      chk("x_co",  {4'b0, co},  5'b00000);
      chk("x_out", {4'b0, out}, 5'b0000x);
      set_in(3'b000); #200;

      // reset in mid operation
      @(negedge clk); #1;
      set_in(3'b111);
      @(posedge clk); #1;
      chk("pre_reset_q", {3'b0, co_q, out_q}, 5'b00011);
      @(negedge clk); #1;
      set_in(3'b110);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst1_q", {3'b0, co_q, out_q}, 5'b00000);
      @(posedge clk); #1;
      chk("rst2_q",    {3'b0, co_q, out_q}, 5'b00000);
      chk("rst2_comb", {3'b0, co, out},     5'b00010);
      @(negedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rel_q", {3'b0, co_q, out_q}, 5'b00010);

      // registered latency: 1 -> 0 -> 1
      @(negedge clk); #1;
      set_in(3'b111);
      @(posedge clk); #1;
      chk("lat1", {3'b0, co_q, out_q}, 5'b00011);
      @(negedge clk); #1;
      set_in(3'b000);
      #200;
      chk("lat_hold", {3'b0, co_q, out_q}, 5'b00011);
      @(posedge clk); #1;
      chk("lat0", {3'b0, co_q, out_q}, 5'b00000);
      @(negedge clk); #1;
      set_in(3'b111);
      @(posedge clk); #1;
      chk("lat1b", {3'b0, co_q, out_q}, 5'b00011);

      // ripple chain
      ca = 4'b0111; cb = 4'b0001; cci = 1'b0;
      #1000;
      chk("chain_model_a", 5'(ca) + 5'(cb), 5'b01000);
      chk("chain_a", {cc[4], csum}, 5'b01000);
      ca = 4'b1111; cb = 4'b0001; cci = 1'b0;
      #1000;
      chk("chain_model_b", 5'(ca) + 5'(cb), 5'b10000);
      chk("chain_b", {cc[4], csum}, 5'b10000);

`ifdef FULLADDER_SELFCHECK_EN
      @(negedge clk); #1;
      pause_cmp = 1'b1;
      set_in(3'b000);
      #200;
      force dut.out = 1'b1;
      @(posedge clk); #1;
      release dut.out;
      #200;
      chk("sc_err_set", {4'b0, err}, 5'b00001);
      repeat (3) @(posedge clk);
      #1;
      chk("sc_err_sticky", {4'b0, err}, 5'b00001);
      @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("sc_err_clr", {4'b0, err}, 5'b00000);
      @(negedge clk); #1;
      reset = 1'b0;
      pause_cmp = 1'b0;
`else
      chk("err_tied", {4'b0, err}, 5'b00000);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- 1-bit gate-level full adder. It is the per-bit cell of the ripple-carry adder_64 datapath adder (64 instances chained carry-to-carry).
- Provides combinational sum/carry outputs with modelled gate delays.
- Also provides a registered copy of sum/carry on the single CPU clock, plus propagate/generate terms for lookahead users.
- Simulation timescale: 1ps/1fs.

Parameters:
- GATE_DELAY, 50, propagation delay in ps applied to every primitive gate (xor/and/or) in the combinational core.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  synchronous, active-high reset; affects registered outputs only.
- a  input  1  addend bit.
- b  input  1  addend bit.
- ci  input  1  carry-in.
- out  output  1  combinational sum = a ^ b ^ ci.
- co  output  1  combinational carry-out = (a & b) | (ci & (a ^ b)).
- p  output  1  propagate = a ^ b.
- g  output  1  generate = a & b.
- out_q  output  1  registered out.
- co_q  output  1  registered co.
- err  output  1  self-check mismatch flag; tied 0 when the optional feature is off.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Combinational core is built only from gate primitives, each with #GATE_DELAY:
  - x1 = a xor b (also drives p)
  - out = x1 xor ci
  - g = a and b
  - t = x1 and ci
  - co = g or t
- Worst-case settle times:
  - p, g: 1×GATE_DELAY.
  - out: 2×GATE_DELAY (100 ps default).
  - co: 3×GATE_DELAY (150 ps default).
- out, co, p and g do not depend on clk or reset; they follow the inputs at all times, including while reset is high.
- Unknown inputs propagate per primitive semantics. Example: a=0, b=0, ci=X gives co=0 and out=X. No X-masking is added.
- Registered stage, on each rising clk edge:
  - reset=1: out_q=0, co_q=0 (and err=0).
  - reset=0: out_q <= out, co_q <= co.
- Reset values: out_q=0, co_q=0, err=0. Before the first clock edge with reset asserted, these outputs are X.
- Latency: 1 cycle from a settled input to out_q/co_q. Callers must hold inputs stable at least 3×GATE_DELAY before the capturing edge; with less setup, the capture of a stale value is acceptable.
- Reset asserted in the middle of operation clears the registers on the next edge. The combinational outputs are unaffected.
- Ripple-chain use: co of bit i connects to ci of bit i+1. No internal state may alter the combinational carry.

Optional Feature:
- Macro: FULLADDER_SELFCHECK_EN.
- Defined:
  - On each rising clk edge with reset=0, the 2-bit value {co, out} is compared with the behavioural sum a + b + ci (zero-extended to 2 bits).
  - Any mismatch on known inputs sets err=1. err is sticky until reset.
  - A mismatch also issues $error with the simulation time and the input values.
  - Inputs containing X/Z are skipped (no error raised).
- Not defined: err is constant 0, no checker logic is elaborated, and the ports are unchanged.

Test Plan:
- Exhaustive: apply all 8 {a,b,ci} combos, waiting 200 ps after each -> {co,out} = 00, 01, 01, 10, 01, 10, 10, 11 for inputs 000…111; p = a^b and g = a&b at each step.
- Timing: a=0, b=0, ci=0, then at t0 set a=1, b=1, ci=1 -> out=1 and co=1 settle no later than t0+100 ps and t0+150 ps respectively; at t0+40 ps, out and co still hold their old values.
- Reset: assert reset for 2 cycles with a=1, b=1, ci=0 -> out_q=0, co_q=0, while out=0, co=1 combinationally; release reset -> next edge gives out_q=0, co_q=1.
- Registered latency: change inputs 1→0→1 at mid-cycle -> out_q/co_q reflect each vector exactly one edge later.
- Chain: instantiate 4 cells in a ripple chain, add 0111 + 0001 with ci=0 -> sum 1000, final co=0; 1111 + 0001 -> sum 0000, co=1.
- Self-check (FULLADDER_SELFCHECK_EN defined): force out to the wrong value for one edge -> err=1 and stays 1 until reset; undefined macro -> err=0 throughout.
